msu_coef_normalize: RTL and testbench

MSU_COEF_NORMALIZE -- requirements
Module: msu_coef_normalize

---
 rtl/msu_coef_normalize.sv | 154 +++++++++++++++
 tb/tb_msu_coef_normalize.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/msu_coef_normalize.sv
// -----------------------------------------------------------------------------
// msu_coef_normalize
//
// Purpose:
//   Converts a vector of redundant-form coefficients (each up to BIT_LEN
//   significant bits, stored in a 2*WORD_LEN-bit field) into the same value
//   in a canonical radix-2^WORD_LEN form.
//   The block works one word per cycle by propagating carries serially from
//   word 0 upward. The result is exact: {carry_out, norm_out} equals
//   sum_j c_j * 2^(WORD_LEN*j), and no modular reduction is applied.
//
// Ports:
//   clk        : clock; all state updates on its rising edge
//   reset      : asynchronous, active-high reset
//   valid_in   : single-cycle pulse; sq_in carries a new job
//   sq_in      : packed coefficients; coefficient j is in field
//                [j*2*WORD_LEN +: 2*WORD_LEN], and only the low BIT_LEN bits
//                of each field are used
//   ready      : high while idle; a valid_in is accepted only then
//   valid_out  : single-cycle pulse; norm_out and carry_out have just updated
//   norm_out   : normalized value, WORD_LEN bits per word
//   carry_out  : carry beyond the top word
//   overrun    : sticky flag; a valid_in arrived while busy and was dropped
// -----------------------------------------------------------------------------
module msu_coef_normalize #(
  parameter int MOD_LEN               = 1024,
  parameter int WORD_LEN              = 16,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
  parameter int BIT_LEN               = 17,
  parameter int SQ_IN_BITS            = NUM_ELEMENTS * WORD_LEN * 2,
  parameter int OUT_BITS              = NUM_ELEMENTS * WORD_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [SQ_IN_BITS-1:0] sq_in,
  output logic                  ready,
  output logic                  valid_out,
  output logic [OUT_BITS-1:0]   norm_out,
  output logic [1:0]            carry_out,
  output logic                  overrun
);

  localparam int CNT_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int SUM_W = BIT_LEN + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEMENTS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           carry_q;
  logic [OUT_BITS-1:0]  work_q;
  logic [BIT_LEN-1:0]   coef_q [NUM_ELEMENTS];

  logic [BIT_LEN-1:0]   coef_sel;
  logic [SUM_W-1:0]     sum_d;
  logic [1:0]           carry_d;
  logic [OUT_BITS-1:0]  work_d;

  logic accept;
  assign accept = (state_q == IDLE) && valid_in;
  assign ready  = (state_q == IDLE);

  // Input register: only the significant bits of each field are kept, so the
  // ignored upper bits never reach the datapath. No reset is needed because
  // every element is rewritten on each accept before it is read.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_capture
      always_ff @(posedge clk) begin
        if (accept) begin
          coef_q[gi] <= sq_in[gi*2*WORD_LEN +: BIT_LEN];
        end
      end
    end
  endgenerate

  // Select the coefficient addressed by the counter. The compare-based mux
  // keeps the selection inside the array bounds for any counter value.
  always_comb begin
    coef_sel = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      if (cnt_q == CNT_W'(j)) begin
        coef_sel = coef_q[j];
      end
    end
  end

  // One carry-propagation step. The sum fits in BIT_LEN+1 bits because the
  // incoming carry is at most 2, and the outgoing carry is again at most 2.
  assign sum_d   = SUM_W'(coef_sel) + SUM_W'(carry_q);
  assign carry_d = 2'(sum_d >> WORD_LEN);

  // Working register with word cnt_q replaced by the freshly normalized word.
  always_comb begin
    work_d = work_q;
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      if (cnt_q == CNT_W'(j)) begin
        work_d[j*WORD_LEN +: WORD_LEN] = sum_d[WORD_LEN-1:0];
      end
    end
  end

  // Control FSM and datapath state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= '0;
      work_q    <= '0;
      norm_out  <= '0;
      carry_out <= '0;
      valid_out <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            cnt_q   <= '0;
            carry_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // A request while busy is dropped and only remembered as overrun.
          if (valid_in) begin
            overrun <= 1'b1;
          end
          work_q  <= work_d;
          carry_q <= carry_d;
          if (cnt_q == LAST_IDX) begin
            // The last element is folded straight into the outputs so that
            // completion happens on the same edge that processes it.
            norm_out  <= work_d;
            carry_out <= carry_d;
            valid_out <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msu_coef_normalize.sv
// -----------------------------------------------------------------------------
// tb_msu_coef_normalize
//
// Self-checking bench for msu_coef_normalize with default parameters.
// Directed vectors come from a table with hand-derived expectations; random
// jobs are compared with an arithmetic model that sums the coefficients
// directly. Multi-cycle corner cases (overrun, back-to-back, reset mid-job)
// are written out as explicit sequences.
// -----------------------------------------------------------------------------
module tb_msu_coef_normalize;

  localparam int NUM = 66;
  localparam int W   = 16;
  localparam int BL  = 17;
  localparam int SQB = NUM * W * 2;
  localparam int OB  = NUM * W;
  localparam int VB  = OB + 2;
  localparam int LAT = NUM + 1;

  logic           clk;
  logic           reset;
  logic           valid_in;
  logic [SQB-1:0] sq_in;
  logic           ready;
  logic           valid_out;
  logic [OB-1:0]  norm_out;
  logic [1:0]     carry_out;
  logic           overrun;

  int pass_cnt  = 0;
  int total_cnt = 0;

  msu_coef_normalize dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .sq_in     (sq_in),
    .ready     (ready),
    .valid_out (valid_out),
    .norm_out  (norm_out),
    .carry_out (carry_out),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [SQB-1:0] sq;
    logic [OB-1:0]  norm;
    logic [1:0]     carry;
  } vec_t;

  vec_t vecs[5];

  // Value of the coefficient vector as a plain integer sum.
  function automatic logic [VB-1:0] model(input logic [SQB-1:0] sq);
    logic [VB-1:0] acc;
    acc = '0;
    for (int j = 0; j < NUM; j++) begin
      acc = acc + (VB'(sq[j*2*W +: BL]) << (W * j));
    end
    return acc;
  endfunction

  // Compare wide values; on mismatch report the first differing 16-bit word
  // so the line stays short.
  task automatic check(input string name, input logic [VB-1:0] got,
                       input logic [VB-1:0] exp);
    logic [VB-1:0] g;
    logic [VB-1:0] e;
    int            idx;
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      idx = 0;
      for (int i = NUM; i >= 0; i--) begin
        g = got >> (W * i);
        e = exp >> (W * i);
        if (g[W-1:0] !== e[W-1:0]) idx = i;
      end
      g = got >> (W * idx);
      e = exp >> (W * idx);
      $display("FAIL %s: word %0d got %h required %h", name, idx, g[W-1:0], e[W-1:0]);
    end
  endtask

  // Drive a one-cycle valid_in; called at a falling edge, returns at the
  // falling edge just after the accepting rising edge.
  task automatic issue(input logic [SQB-1:0] sq);
    sq_in    = sq;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Wait (bounded) for valid_out; lat counts cycles since the accept edge.
  task automatic wait_done(input int start, output logic [VB-1:0] res, output int lat);
    lat = start;
    while (valid_out !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = {carry_out, norm_out};
  endtask

  logic [SQB-1:0] sq_a, sq_b, sq_c, sq_r;
  logic [VB-1:0]  res;
  logic [VB-1:0]  held;
  int             lat;
  int             seen;

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    sq_in    = '0;

    // Directed table
    vecs[0].name = "zeros";
    vecs[0].sq = '0;  vecs[0].norm = '0;  vecs[0].carry = 2'd0;

    vecs[1].name = "c0_0x10000";
    vecs[1].sq = '0;  vecs[1].sq[31:0] = 32'h0001_0000;
    vecs[1].norm = '0; vecs[1].norm[31:16] = 16'h0001; vecs[1].carry = 2'd0;

    vecs[2].name = "all_1ffff";
    vecs[2].norm = '0;
    for (int j = 0; j < NUM; j++) begin
      vecs[2].sq[j*32 +: 32] = 32'h0001_FFFF;
      vecs[2].norm[j*W +: W] = (j == 0) ? 16'hFFFF : (j == 1) ? 16'h0000 : 16'h0001;
    end
    vecs[2].carry = 2'd2;

    vecs[3].name = "upper_ignored";
    vecs[3].sq = '0;  vecs[3].sq[31:0] = 32'hFFFE_0003;
    vecs[3].norm = '0; vecs[3].norm[15:0] = 16'h0003; vecs[3].carry = 2'd0;

    vecs[4].name = "top_elem_max";
    vecs[4].sq = '0;  vecs[4].sq[(NUM-1)*32 +: 32] = 32'hABCD_FFFF;
    vecs[4].norm = '0; vecs[4].norm[(NUM-1)*W +: W] = 16'hFFFF; vecs[4].carry = 2'd1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_value", {carry_out, norm_out}, '0);
    check("reset_ready", VB'(ready), VB'(1));
    check("reset_valid_out", VB'(valid_out), VB'(0));
    check("reset_overrun", VB'(overrun), VB'(0));
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      issue(vecs[i].sq);
      wait_done(1, res, lat);
      check({vecs[i].name, "_value"}, res, {vecs[i].carry, vecs[i].norm});
      check({vecs[i].name, "_latency"}, VB'(lat), VB'(LAT));
      @(negedge clk);
      check({vecs[i].name, "_pulse"}, VB'(valid_out), VB'(0));
      $display("vector %s: latency %0d carry %0d", vecs[i].name, lat, carry_out);
    end

    // Random jobs vs. arithmetic model
    for (int t = 0; t < 10; t++) begin
      for (int j = 0; j < NUM; j++) begin
        sq_r[j*32 +: 32] = $urandom();
        if ($urandom_range(0, 3) == 0) sq_r[j*32 +: 17] = 17'h1FFFF;
      end
      @(negedge clk);
      issue(sq_r);
      wait_done(1, res, lat);
      check("random_value", res, model(sq_r));
      check("random_latency", VB'(lat), VB'(LAT));
      $display("random job %0d: latency %0d carry %0d", t, lat, carry_out);
    end
    held = model(sq_r);

    // Overrun, then back-to-back accept on the valid_out cycle
    for (int j = 0; j < NUM; j++) begin
      sq_a[j*32 +: 32] = $urandom();
      sq_b[j*32 +: 32] = $urandom();
      sq_c[j*32 +: 32] = $urandom();
    end
    @(negedge clk);
    issue(sq_a);
    repeat (4) @(negedge clk);
    issue(sq_b);
    check("overrun_set", VB'(overrun), VB'(1));
    check("hold_during_run", {carry_out, norm_out}, held);
    wait_done(6, res, lat);
    check("overrun_first_value", res, model(sq_a));
    check("overrun_first_latency", VB'(lat), VB'(LAT));
    $display("overrun job A: latency %0d", lat);
    issue(sq_c);
    check("b2b_hold_old", {carry_out, norm_out}, model(sq_a));
    check("b2b_valid_pulse", VB'(valid_out), VB'(0));
    wait_done(1, res, lat);
    check("b2b_value", res, model(sq_c));
    check("b2b_latency", VB'(lat), VB'(LAT));
    check("overrun_sticky", VB'(overrun), VB'(1));
    $display("back-to-back job C: latency %0d", lat);

    // Reset in the middle of a job
    @(negedge clk);
    issue(sq_a);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_value", {carry_out, norm_out}, '0);
    check("midreset_overrun", VB'(overrun), VB'(0));
    check("midreset_ready", VB'(ready), VB'(1));
    check("midreset_valid_out", VB'(valid_out), VB'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (valid_out === 1'b1) seen++;
    end
    check("midreset_no_valid_out", VB'(seen), VB'(0));
    issue(sq_b);
    wait_done(1, res, lat);
    check("after_reset_value", res, model(sq_b));
    check("after_reset_latency", VB'(lat), VB'(LAT));
    check("after_reset_overrun", VB'(overrun), VB'(0));
    $display("post-reset job: latency %0d", lat);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
